icache_fill: RTL and testbench

ICACHE_FILL -- requirements
Module: icache_fill

---
 rtl/icache_fill.sv | 129 ++++++++++++
 tb/tb_icache_fill.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a word-serial line fill from backing memory.
// Lookups are combinational; a miss stalls fetch until the whole line is written back.
module icache_fill #(
  parameter int LINES = 16,
  parameter int WORDS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        FETCH_EN,
  input  logic        INVALIDATE,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [15:0] HIT_CNT,
  output logic [15:0] MISS_CNT
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, RESTART} state_t;

  state_t state, state_nxt;

  logic [31:0]      data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [OFF_W-1:0] cnt;
  logic             inv_pend;
  logic [15:0]      hit_cnt, miss_cnt;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             hit, miss, ack, last;
  logic             unused_pc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pc_off    = PC[2 +: OFF_W];
  assign pc_idx    = PC[2+OFF_W +: IDX_W];
  assign pc_tag    = PC[31 -: TAG_W];
  assign unused_pc = ^PC[1:0];

  assign hit  = (state == IDLE) && FETCH_EN && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss = (state == IDLE) && FETCH_EN && !hit;
  assign ack  = (state == FILL) && MEM_ACK;
  assign last = ack && (cnt == OFF_W'(WORDS - 1));

  assign INSTR    = data_mem[{pc_idx, pc_off}];
  assign HIT_CNT  = hit_cnt;
  assign MISS_CNT = miss_cnt;

  always_comb begin
    state_nxt   = state;
    INSTR_VALID = 1'b0;
    STALL       = 1'b0;
    MEM_REQ     = 1'b0;
    MEM_ADDR    = 32'd0;
    case (state)
      IDLE: begin
        INSTR_VALID = hit;
        STALL       = miss;
        if (miss) state_nxt = FILL;
      end
      FILL: begin
        STALL    = 1'b1;
        MEM_REQ  = 1'b1;
        MEM_ADDR = {miss_tag, miss_idx, cnt, 2'b00};
        if (last) state_nxt = RESTART;
      end
      RESTART: begin
        STALL     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, fill counter, pending invalidate, statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      valid    <= '0;
      cnt      <= '0;
      inv_pend <= 1'b0;
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (hit) hit_cnt <= sat_inc(hit_cnt);
      if (miss) begin
        miss_cnt <= sat_inc(miss_cnt);
        cnt      <= '0;
      end
      if (ack) cnt <= cnt + 1'b1;
      // A deferred invalidate lands on the RESTART->IDLE edge, wiping the fresh line too
      if ((state == IDLE) && INVALIDATE)
        valid <= '0;
      else if ((state == RESTART) && (inv_pend || INVALIDATE))
        valid <= '0;
      else if (last)
        valid[miss_idx] <= 1'b1;
      if (state == RESTART)
        inv_pend <= 1'b0;
      else if ((state == FILL) && INVALIDATE)
        inv_pend <= 1'b1;
    end
  end

  // Storage: data/tag arrays and the latched miss address carry no reset
  always_ff @(posedge CLK) begin
    if (miss) begin
      miss_tag <= pc_tag;
      miss_idx <= pc_idx;
    end
    if (!RST && ack) data_mem[{miss_idx, cnt}] <= MEM_RDATA;
    if (!RST && last) tag_mem[miss_idx] <= miss_tag;
  end
endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: miss/fill/restart sequencing, hits, conflicts,
// slow memory, deferred invalidate and reset in the middle of a fill.
module tb_icache_fill;
  localparam int WORDS = 8;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        FETCH_EN;
  logic        INVALIDATE;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        STALL;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic [15:0] HIT_CNT;
  logic [15:0] MISS_CNT;

  int passed = 0;
  int total  = 0;
  logic [31:0] req_log[$];

  icache_fill #(.LINES(16), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .FETCH_EN(FETCH_EN), .INVALIDATE(INVALIDATE),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .STALL(STALL),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], 16'hBEEF} ^ a;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; FETCH_EN = 1'b0; MEM_ACK = 1'b0; INVALIDATE = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] pc);
    @(negedge CLK);
    PC = pc; FETCH_EN = 1'b1;
    #1;
    total++;
    if (STALL !== 1'b1) $display("FAIL miss_stall pc=%h got=%b exp=1", pc, STALL);
    else passed++;
  endtask

  // Memory responder for one fill; optional reset or invalidate at a given ack index
  task automatic serve(input int delay, input int rst_word, input int inv_word,
                       input bit scramble, output int nacks, output int nstall);
    int  w = 0;
    bit  rst_done = 0;
    nacks = 0; nstall = 0;
    req_log.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      INVALIDATE = 1'b0;
      if (STALL) nstall++;
      if (nacks == WORDS || rst_done) begin
        MEM_ACK = 1'b0;
        break;
      end
      if (scramble) PC = 32'hDEAD_0000 + 32'(cyc * 4);
      if (MEM_REQ) begin
        req_log.push_back(MEM_ADDR);
        if (w == delay) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = mdata(MEM_ADDR);
          if (nacks == rst_word) begin
            RST = 1'b1; FETCH_EN = 1'b0; rst_done = 1;
          end
          if (nacks == inv_word) INVALIDATE = 1'b1;
          nacks++;
          w = 0;
        end else begin
          MEM_ACK = 1'b0;
          w++;
        end
      end else begin
        MEM_ACK = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; PC = 32'd0; FETCH_EN = 1'b0; INVALIDATE = 1'b0;
    MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    total++; if (INSTR_VALID !== 1'b0) $display("FAIL rst_valid got=%b exp=0", INSTR_VALID); else passed++;
    total++; if (STALL !== 1'b0) $display("FAIL rst_stall got=%b exp=0", STALL); else passed++;
    total++; if (MEM_REQ !== 1'b0) $display("FAIL rst_req got=%b exp=0", MEM_REQ); else passed++;
    total++; if (MEM_ADDR !== 32'd0) $display("FAIL rst_addr got=%h exp=0", MEM_ADDR); else passed++;
    total++; if (HIT_CNT !== 16'd0) $display("FAIL rst_hit got=%0d exp=0", HIT_CNT); else passed++;
    total++; if (MISS_CNT !== 16'd0) $display("FAIL rst_miss got=%0d exp=0", MISS_CNT); else passed++;
  endtask

  task automatic test_cold_miss();
    int nacks, nstall;
    do_reset();
    start_miss(32'h100);
    serve(0, -1, -1, 0, nacks, nstall);
    total++; if (nacks !== WORDS) $display("FAIL cold_acks got=%0d exp=%0d", nacks, WORDS); else passed++;
    total++; if (nstall < 9) $display("FAIL cold_stall_cycles got=%0d exp>=9", nstall); else passed++;
    total++; if (req_log.size() !== WORDS) $display("FAIL cold_req_count got=%0d exp=%0d", req_log.size(), WORDS); else passed++;
    for (int i = 0; i < WORDS && i < req_log.size(); i++) begin
      total++;
      if (req_log[i] !== 32'h100 + 32'(i * 4)) $display("FAIL cold_addr[%0d] got=%h exp=%h", i, req_log[i], 32'h100 + 32'(i * 4));
      else passed++;
    end
    @(negedge CLK);
    #1;
    total++; if (INSTR_VALID !== 1'b1) $display("FAIL cold_hit_valid got=%b exp=1", INSTR_VALID); else passed++;
    total++; if (INSTR !== mdata(32'h100)) $display("FAIL cold_instr got=%h exp=%h", INSTR, mdata(32'h100)); else passed++;
    total++; if (STALL !== 1'b0) $display("FAIL cold_hit_stall got=%b exp=0", STALL); else passed++;
    total++; if (MISS_CNT !== 16'd1) $display("FAIL cold_miss_cnt got=%0d exp=1", MISS_CNT); else passed++;
    total++; if (HIT_CNT !== 16'd0) $display("FAIL cold_hit_cnt got=%0d exp=0", HIT_CNT); else passed++;
  endtask

  task automatic test_hits();
    for (int i = 1; i < WORDS; i++) begin
      @(negedge CLK);
      PC = 32'h100 + 32'(i * 4);
      #1;
      total++; if (INSTR !== mdata(PC)) $display("FAIL hit_instr[%0d] got=%h exp=%h", i, INSTR, mdata(PC)); else passed++;
      total++; if (INSTR_VALID !== 1'b1 || STALL !== 1'b0 || MEM_REQ !== 1'b0)
        $display("FAIL hit_flags[%0d] got=v%b s%b r%b exp=v1 s0 r0", i, INSTR_VALID, STALL, MEM_REQ);
      else passed++;
      total++; if (HIT_CNT !== 16'(i)) $display("FAIL hit_cnt[%0d] got=%0d exp=%0d", i, HIT_CNT, i); else passed++;
    end
    @(negedge CLK);
    FETCH_EN = 1'b0;
    #1;
    total++; if (HIT_CNT !== 16'd8) $display("FAIL hit_cnt_final got=%0d exp=8", HIT_CNT); else passed++;
    total++; if (INSTR_VALID !== 1'b0 || STALL !== 1'b0)
      $display("FAIL idle_noreq got=v%b s%b exp=v0 s0", INSTR_VALID, STALL);
    else passed++;
  endtask

  task automatic test_conflict();
    int nacks, nstall;
    logic [31:0] addrs [3];
    addrs[0] = 32'h000; addrs[1] = 32'h200; addrs[2] = 32'h000;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      start_miss(addrs[k]);
      serve(0, -1, -1, 0, nacks, nstall);
      total++;
      if (nacks !== WORDS || req_log.size() == 0 || req_log[0] !== addrs[k])
        $display("FAIL conflict_fill[%0d] got acks=%0d first=%h exp acks=%0d first=%h", k, nacks,
                 (req_log.size() > 0) ? req_log[0] : 32'hX, WORDS, addrs[k]);
      else passed++;
      @(negedge CLK);
      #1;
      total++;
      if (INSTR_VALID !== 1'b1 || INSTR !== mdata(addrs[k]))
        $display("FAIL conflict_hit[%0d] got v=%b d=%h exp v=1 d=%h", k, INSTR_VALID, INSTR, mdata(addrs[k]));
      else passed++;
    end
    total++; if (MISS_CNT !== 16'd3) $display("FAIL conflict_miss_cnt got=%0d exp=3", MISS_CNT); else passed++;
    FETCH_EN = 1'b0;
  endtask

  task automatic test_slow();
    int nacks, nstall;
    do_reset();
    start_miss(32'h340);
    serve(3, -1, -1, 1, nacks, nstall);
    total++; if (nacks !== WORDS) $display("FAIL slow_acks got=%0d exp=%0d", nacks, WORDS); else passed++;
    total++; if (req_log.size() !== 4 * WORDS) $display("FAIL slow_req_cycles got=%0d exp=%0d", req_log.size(), 4 * WORDS); else passed++;
    for (int i = 0; i < req_log.size() && i < 4 * WORDS; i++) begin
      total++;
      if (req_log[i] !== 32'h340 + 32'((i / 4) * 4))
        $display("FAIL slow_addr_stable[%0d] got=%h exp=%h", i, req_log[i], 32'h340 + 32'((i / 4) * 4));
      else passed++;
    end
    for (int i = 0; i < WORDS; i++) begin
      @(negedge CLK);
      PC = 32'h340 + 32'(i * 4); FETCH_EN = 1'b1;
      #1;
      total++;
      if (INSTR_VALID !== 1'b1 || INSTR !== mdata(PC))
        $display("FAIL slow_word[%0d] got v=%b d=%h exp v=1 d=%h", i, INSTR_VALID, INSTR, mdata(PC));
      else passed++;
    end
    @(negedge CLK);
    FETCH_EN = 1'b0;
  endtask

  task automatic test_invalidate();
    int nacks, nstall;
    do_reset();
    start_miss(32'h100);
    serve(0, -1, 2, 0, nacks, nstall);
    total++; if (nacks !== WORDS) $display("FAIL inv_fill_acks got=%0d exp=%0d", nacks, WORDS); else passed++;
    @(negedge CLK);
    PC = 32'h100;
    #1;
    total++; if (STALL !== 1'b1 || INSTR_VALID !== 1'b0)
      $display("FAIL inv_pending_miss got=s%b v%b exp=s1 v0", STALL, INSTR_VALID);
    else passed++;
    serve(0, -1, -1, 0, nacks, nstall);
    total++; if (MISS_CNT !== 16'd2) $display("FAIL inv_miss_cnt got=%0d exp=2", MISS_CNT); else passed++;
    // Invalidate in IDLE: same-cycle lookup still hits, next cycle misses
    @(negedge CLK);
    INVALIDATE = 1'b1;
    #1;
    total++; if (INSTR_VALID !== 1'b1) $display("FAIL inv_same_cycle_hit got=%b exp=1", INSTR_VALID); else passed++;
    @(negedge CLK);
    INVALIDATE = 1'b0;
    #1;
    total++; if (INSTR_VALID !== 1'b0 || STALL !== 1'b1)
      $display("FAIL inv_next_cycle got=v%b s%b exp=v0 s1", INSTR_VALID, STALL);
    else passed++;
    FETCH_EN = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    int nacks, nstall;
    do_reset();
    start_miss(32'h100);
    serve(0, 3, -1, 0, nacks, nstall);
    #1;
    total++; if (nacks !== 4) $display("FAIL rmf_acks got=%0d exp=4", nacks); else passed++;
    total++; if (MEM_REQ !== 1'b0 || MEM_ADDR !== 32'd0)
      $display("FAIL rmf_req got=r%b a=%h exp=r0 a=0", MEM_REQ, MEM_ADDR);
    else passed++;
    total++; if (STALL !== 1'b0 || INSTR_VALID !== 1'b0 || MISS_CNT !== 16'd0)
      $display("FAIL rmf_state got=s%b v%b m=%0d exp=s0 v0 m=0", STALL, INSTR_VALID, MISS_CNT);
    else passed++;
    RST = 1'b0;
    start_miss(32'h100);
    serve(0, -1, -1, 0, nacks, nstall);
    total++;
    if (nacks !== WORDS || req_log.size() == 0 || req_log[0] !== 32'h100)
      $display("FAIL rmf_refetch got acks=%0d first=%h exp acks=%0d first=00000100", nacks,
               (req_log.size() > 0) ? req_log[0] : 32'hX, WORDS);
    else passed++;
    @(negedge CLK);
    #1;
    total++;
    if (INSTR_VALID !== 1'b1 || INSTR !== mdata(32'h100) || MISS_CNT !== 16'd1)
      $display("FAIL rmf_hit got v=%b d=%h m=%0d exp v=1 d=%h m=1", INSTR_VALID, INSTR, MISS_CNT, mdata(32'h100));
    else passed++;
    FETCH_EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_slow();
    test_invalidate();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
